// File: rtl/tiny_dnn_ex_seq.sv
// Execution sequencer for the tiny-dnn conv/FC datapath: walks dc/oy/ox x ic/fy/fx and emits buffer addresses.
// Optional macro TINY_DNN_EX_SEQ_STRIDE_EN enables the runtime forward stride (otherwise stride is ignored).
module tiny_dnn_ex_seq #(
   parameter int DW  = 4,
   parameter int SW  = 5,
   parameter int IAW = 12,
   parameter int WAW = 10,
   parameter int STW = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_init,
   input  logic           backprop,
   input  logic           out_busy,
   input  logic           outr,
   input  logic [DW-1:0]  dd,
   input  logic [DW-1:0]  id,
   input  logic [IAW-1:0] is,
   input  logic [SW-1:0]  ih,
   input  logic [SW-1:0]  iw,
   input  logic [SW-1:0]  oh,
   input  logic [SW-1:0]  ow,
   input  logic [WAW-1:0] fs,
   input  logic [WAW-1:0] ks,
   input  logic [SW-1:0]  kh,
   input  logic [SW-1:0]  kw,
   input  logic [STW-1:0] stride,
   output logic           busy,
   output logic           k_init,
   output logic           k_fin,
   output logic           exec,
   output logic [IAW-1:0] ia,
   output logic [WAW-1:0] wa,
   output logic           s_fin
);
   localparam int YW = SW + STW + 1;

   typedef enum logic [2:0] {IDLE, KINIT, EXEC, KFIN, WAIT, DONE} state_t;

   state_t         state_q;
   logic [DW-1:0]  dc_q, ic_q;
   logic [SW-1:0]  oy_q, ox_q, fy_q, fx_q;
   logic           fin_q;
   logic [2:0]     dly_q;

   logic           bp_q;
   logic [DW-1:0]  dd_q, id_q;
   logic [IAW-1:0] is_q;
   logic [SW-1:0]  ih_q, iw_q, oh_q, ow_q, kh_q, kw_q;
   logic [WAW-1:0] fs_q, ks_q;

   logic signed [YW-1:0] yy_c, xx_c;
   logic [SW-1:0]  sy_c, ey_c, sx_c, ex_c;
   logic [IAW-1:0] row_c, col_c, ia_c;
   logic [WAW-1:0] wa_c;
   logic           inner_last, outer_last;

   function automatic logic signed [YW-1:0] bp_base(input logic [SW-1:0] o, input logic [SW-1:0] k);
      logic signed [SW:0] d;
      d = $signed({1'b0, o}) - $signed({1'b0, k});
      return YW'(d);
   endfunction

   function automatic logic [SW-1:0] bp_start(input logic signed [YW-1:0] b);
      return b[YW-1] ? SW'(-b) : '0;
   endfunction

   // Rows/columns past the input edge shrink the kernel window from the far side.
   function automatic logic [SW-1:0] bp_end(input logic signed [YW-1:0] b, input logic [SW-1:0] o,
                                            input logic [SW-1:0] i, input logic [SW-1:0] k);
      return (o > i) ? SW'($signed(YW'(i)) - b) : k;
   endfunction

`ifdef TINY_DNN_EX_SEQ_STRIDE_EN
   logic [STW-1:0] st_q;

   function automatic logic signed [YW-1:0] fw_base(input logic [SW-1:0] o, input logic [STW-1:0] s);
      logic [STW-1:0] st;
      st = (s == '0) ? STW'(1) : s;
      return $signed({1'b0, (YW-1)'(o) * (YW-1)'(st)});
   endfunction

   always_ff @(posedge clk) begin
      if (state_q == IDLE && s_init) st_q <= stride;
   end

   always_comb begin
      yy_c = bp_q ? bp_base(oy_q, kh_q) : fw_base(oy_q, st_q);
      xx_c = bp_q ? bp_base(ox_q, kw_q) : fw_base(ox_q, st_q);
   end
`else
   logic unused_stride;
   assign unused_stride = ^stride;

   function automatic logic signed [YW-1:0] fw_base(input logic [SW-1:0] o);
      return $signed({1'b0, (YW-1)'(o)});
   endfunction

   always_comb begin
      yy_c = bp_q ? bp_base(oy_q, kh_q) : fw_base(oy_q);
      xx_c = bp_q ? bp_base(ox_q, kw_q) : fw_base(ox_q);
   end
`endif

   always_comb begin
      sy_c = bp_q ? bp_start(yy_c) : '0;
      sx_c = bp_q ? bp_start(xx_c) : '0;
      ey_c = bp_q ? bp_end(yy_c, oy_q, ih_q, kh_q) : kh_q;
      ex_c = bp_q ? bp_end(xx_c, ox_q, iw_q, kw_q) : kw_q;
   end

   always_comb begin
      row_c = IAW'(yy_c + YW'($signed({1'b0, fy_q})));
      col_c = IAW'(xx_c + YW'($signed({1'b0, fx_q})));
      ia_c  = IAW'(dc_q) * is_q + IAW'(ic_q) * is_q + row_c * (IAW'(iw_q) + IAW'(1)) + col_c;
      wa_c  = WAW'(dc_q) * fs_q + WAW'(ic_q) * (ks_q + WAW'(1))
            + WAW'(fy_q) * (WAW'(kw_q) + WAW'(1)) + WAW'(fx_q);
   end

   assign inner_last = (fx_q == ex_c) && (fy_q == ey_c) && (ic_q == id_q);
   assign outer_last = (dc_q == dd_q) && (oy_q == oh_q) && (ox_q == ow_q);

   // Configuration is captured when a sequence is accepted and held for its duration.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && s_init) begin
         bp_q <= backprop;
         dd_q <= dd;
         id_q <= id;
         is_q <= is;
         ih_q <= ih;
         iw_q <= iw;
         oh_q <= oh;
         ow_q <= ow;
         fs_q <= fs;
         ks_q <= ks;
         kh_q <= kh;
         kw_q <= kw;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dc_q    <= '0;
         ic_q    <= '0;
         oy_q    <= '0;
         ox_q    <= '0;
         fy_q    <= '0;
         fx_q    <= '0;
         fin_q   <= 1'b0;
         dly_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (s_init) begin
                  state_q <= KINIT;
                  dc_q    <= '0;
                  oy_q    <= '0;
                  ox_q    <= '0;
               end
            end
            KINIT: begin
               state_q <= EXEC;
               ic_q    <= '0;
               fy_q    <= sy_c;
               fx_q    <= sx_c;
            end
            EXEC: begin
               if (fx_q != ex_c) begin
                  fx_q <= fx_q + SW'(1);
               end else begin
                  fx_q <= sx_c;
                  if (fy_q != ey_c) begin
                     fy_q <= fy_q + SW'(1);
                  end else begin
                     fy_q <= sy_c;
                     ic_q <= ic_q + DW'(1);
                  end
               end
               if (inner_last) begin
                  state_q <= KFIN;
                  fin_q   <= outer_last;
                  if (ox_q != ow_q) begin
                     ox_q <= ox_q + SW'(1);
                  end else begin
                     ox_q <= '0;
                     if (oy_q != oh_q) begin
                        oy_q <= oy_q + SW'(1);
                     end else begin
                        oy_q <= '0;
                        dc_q <= dc_q + DW'(1);
                     end
                  end
               end
            end
            KFIN: begin
               if (fin_q) begin
                  state_q <= DONE;
                  dly_q   <= 3'd2;
               end else if (!out_busy) begin
                  state_q <= EXEC;
                  ic_q    <= '0;
                  fy_q    <= sy_c;
                  fx_q    <= sx_c;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (!out_busy) begin
                  state_q <= EXEC;
                  ic_q    <= '0;
                  fy_q    <= sy_c;
                  fx_q    <= sx_c;
               end
            end
            DONE: begin
               // dly_q counts cycles since the final exec cycle.
               if (dly_q >= 3'd4 && !outr) begin
                  state_q <= IDLE;
               end else if (dly_q < 3'd4) begin
                  dly_q <= dly_q + 3'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign exec   = (state_q == EXEC);
   assign k_fin  = (state_q == KFIN);
   assign k_init = (state_q == KINIT) | ((state_q == KFIN) & ~fin_q & ~out_busy)
                 | ((state_q == WAIT) & ~out_busy);
   assign s_fin  = (state_q == DONE) & (dly_q >= 3'd4) & ~outr;
   assign ia     = exec ? ia_c : '0;
   assign wa     = exec ? wa_c : '0;

endmodule

// File: tb/tb_tiny_dnn_ex_seq.sv
// Scoreboard bench for tiny_dnn_ex_seq: a loop-nest model fills the expected address queue, a monitor drains it.
module tb_tiny_dnn_ex_seq;
   localparam int DW = 4, SW = 5, IAW = 12, WAW = 10, STW = 2;

   logic clk = 1'b0;
   logic rst, s_init, backprop, out_busy, outr;
   logic [DW-1:0]  dd, id;
   logic [IAW-1:0] is;
   logic [SW-1:0]  ih, iw, oh, ow, kh, kw;
   logic [WAW-1:0] fs, ks;
   logic [STW-1:0] stride;
   logic busy, k_init, k_fin, exec, s_fin;
   logic [IAW-1:0] ia;
   logic [WAW-1:0] wa;

   tiny_dnn_ex_seq #(.DW(DW), .SW(SW), .IAW(IAW), .WAW(WAW), .STW(STW)) dut (
      .clk(clk), .rst(rst), .s_init(s_init), .backprop(backprop), .out_busy(out_busy), .outr(outr),
      .dd(dd), .id(id), .is(is), .ih(ih), .iw(iw), .oh(oh), .ow(ow), .fs(fs), .ks(ks),
      .kh(kh), .kw(kw), .stride(stride), .busy(busy), .k_init(k_init), .k_fin(k_fin),
      .exec(exec), .ia(ia), .wa(wa), .s_fin(s_fin)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;
   int c_bp, c_dd, c_id, c_is, c_ih, c_iw, c_oh, c_ow, c_fs, c_ks, c_kh, c_kw, c_stride;

   int exp_ia[$], exp_wa[$];
   int ia_log[$], kfirst_ia[$], kfirst_wa[$], klen[$];
   int exp_kernels = 0, kin_cnt = 0, kfin_cnt = 0, exec_cnt = 0, cur_len = 0;
   int last_exec_cyc = 0, sfin_gap = 0, sfin_cnt = 0;
   bit mon_en = 0, pend = 0, sfin_exp = 0;
   bit prev_exec = 0, prev_kinit = 0, prev_sfin = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         bit was_pend;
         if (exec) begin
            if (exp_ia.size() == 0) begin
               chk("exec_unexpected", 1, 0);
            end else begin
               chk("ia", ia, exp_ia.pop_front());
               chk("wa", wa, exp_wa.pop_front());
            end
            ia_log.push_back(ia);
            if (!prev_exec) begin
               kfirst_ia.push_back(ia);
               kfirst_wa.push_back(wa);
            end
            cur_len++;
            exec_cnt++;
            last_exec_cyc = cyc;
         end
         if (prev_exec && !exec) begin
            klen.push_back(cur_len);
            cur_len = 0;
         end
         if (k_fin || (prev_exec && !exec)) chk("kfin_after_exec", k_fin, prev_exec && !exec);
         if (prev_kinit || (exec && !prev_exec)) chk("kinit_to_exec", prev_kinit && exec, 1);
         if (k_fin) begin
            kfin_cnt++;
            if (kfin_cnt < exp_kernels) pend = 1;
         end
         was_pend = pend;
         if (pend) begin
            chk("kinit_when_free", k_init, !out_busy);
            if (k_init) pend = 0;
         end
         if (k_init) begin
            if (!was_pend && kin_cnt != 0) chk("kinit_spurious", 1, 0);
            kin_cnt++;
         end
         if (s_fin) begin
            chk("sfin_expected", sfin_exp, 1);
            chk("sfin_gap", cyc - last_exec_cyc, sfin_gap);
            chk("busy_at_sfin", busy, 1);
            chk("kernels_done", kfin_cnt, exp_kernels);
            sfin_cnt++;
            sfin_exp = 0;
         end
         if (prev_sfin) chk("busy_after_sfin", busy, 0);
         prev_exec  = exec;
         prev_kinit = k_init;
         prev_sfin  = s_fin;
      end
   end

   task automatic push_model();
      for (int d = 0; d <= c_dd; d++)
         for (int oy = 0; oy <= c_oh; oy++)
            for (int ox = 0; ox <= c_ow; ox++) begin
               int st, yy, xx, sy, ey, sx, ex;
               if (c_bp != 0) begin
                  yy = oy - c_kh;
                  xx = ox - c_kw;
                  sy = (yy < 0) ? -yy : 0;
                  sx = (xx < 0) ? -xx : 0;
                  ey = (oy > c_ih) ? c_ih - yy : c_kh;
                  ex = (ox > c_iw) ? c_iw - xx : c_kw;
               end else begin
`ifdef TINY_DNN_EX_SEQ_STRIDE_EN
                  st = (c_stride == 0) ? 1 : c_stride;
`else
                  st = 1;
`endif
                  yy = oy * st;
                  xx = ox * st;
                  sy = 0; sx = 0; ey = c_kh; ex = c_kw;
               end
               for (int ic = 0; ic <= c_id; ic++)
                  for (int fy = sy; fy <= ey; fy++)
                     for (int fx = sx; fx <= ex; fx++) begin
                        exp_ia.push_back((d*c_is + ic*c_is + (yy+fy)*(c_iw+1) + (xx+fx)) & ((1 << IAW) - 1));
                        exp_wa.push_back((d*c_fs + ic*(c_ks+1) + fy*(c_kw+1) + fx) & ((1 << WAW) - 1));
                     end
            end
      exp_kernels = (c_dd + 1) * (c_oh + 1) * (c_ow + 1);
   endtask

   task automatic set_cfg(input int bp, input int oh_v, input int ow_v, input int ih_v, input int iw_v,
                          input int is_v, input int st_v);
      c_bp = bp; c_dd = 0; c_id = 0; c_is = is_v; c_ih = ih_v; c_iw = iw_v; c_oh = oh_v; c_ow = ow_v;
      c_fs = 4; c_ks = 3; c_kh = 1; c_kw = 1; c_stride = st_v;
      backprop = c_bp[0]; dd = DW'(c_dd); id = DW'(c_id); is = IAW'(c_is);
      ih = SW'(c_ih); iw = SW'(c_iw); oh = SW'(c_oh); ow = SW'(c_ow);
      fs = WAW'(c_fs); ks = WAW'(c_ks); kh = SW'(c_kh); kw = SW'(c_kw); stride = STW'(c_stride);
   endtask

   task automatic start_seq(input int gap);
      ia_log.delete(); kfirst_ia.delete(); kfirst_wa.delete(); klen.delete();
      kin_cnt = 0; kfin_cnt = 0; exec_cnt = 0; cur_len = 0; pend = 0;
      push_model();
      sfin_exp = 1;
      sfin_gap = gap;
      s_init = 1'b1;
      @(posedge clk); #1;
      s_init = 1'b0;
   endtask

   task automatic wait_exec(input int n);
      int k = 0;
      while (exec_cnt < n && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      chk("exec_wait_timeout", exec_cnt >= n, 1);
   endtask

   task automatic wait_sfin();
      int k = 0;
      while (sfin_exp && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      chk("sfin_timeout", sfin_exp, 0);
      chk("queue_drained", exp_ia.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_t1_log();
      int k0[4] = '{0, 1, 3, 4};
      int k3[4] = '{4, 5, 7, 8};
      chk("t1_log_len", ia_log.size(), 16);
      if (ia_log.size() == 16)
         for (int i = 0; i < 4; i++) begin
            chk("t1_k0_ia", ia_log[i], k0[i]);
            chk("t1_k3_ia", ia_log[12+i], k3[i]);
         end
      chk("t1_kernel_cnt", klen.size(), 4);
      for (int i = 0; i < klen.size(); i++) chk("t1_klen", klen[i], 4);
   endtask

   initial begin
      int sfin_before;
      rst = 1'b1; s_init = 1'b0; out_busy = 1'b0; outr = 1'b0;
      set_cfg(0, 1, 1, 2, 2, 9, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_kinit", k_init, 0);
      chk("rst_kfin", k_fin, 0);
      chk("rst_exec", exec, 0);
      chk("rst_ia", ia, 0);
      chk("rst_wa", wa, 0);
      chk("rst_sfin", s_fin, 0);
      rst = 1'b0;
      mon_en = 1;
      @(posedge clk); #1;

      // Forward, unit stride
      set_cfg(0, 1, 1, 2, 2, 9, 0);
      start_seq(4);
      wait_sfin();
      check_t1_log();

      // Forward, stride 2
      set_cfg(0, 1, 1, 4, 4, 9, 2);
      start_seq(4);
      wait_sfin();
      chk("t2_kernel_cnt", kfirst_ia.size(), 4);
      if (kfirst_ia.size() == 4) begin
`ifdef TINY_DNN_EX_SEQ_STRIDE_EN
         chk("t2_k1_ia0", kfirst_ia[1], 2);
         chk("t2_k2_ia0", kfirst_ia[2], 10);
`else
         chk("t2_k1_ia0", kfirst_ia[1], 1);
         chk("t2_k2_ia0", kfirst_ia[2], 5);
`endif
      end

      // Backprop, stride ignored
      set_cfg(1, 2, 2, 1, 1, 4, 3);
      start_seq(4);
      wait_sfin();
      chk("t3_kernel_cnt", klen.size(), 9);
      if (klen.size() > 0) begin
         chk("t3_k0_len", klen[0], 1);
         chk("t3_k0_ia", kfirst_ia[0], 0);
         chk("t3_k0_wa", kfirst_wa[0], 3);
      end

      // Output stage busy across a kernel boundary
      set_cfg(0, 1, 1, 2, 2, 9, 0);
      start_seq(4);
      wait_exec(2);
      out_busy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      out_busy = 1'b0;
      wait_sfin();
      chk("t4_log_len", ia_log.size(), 16);

      // Output stage draining past the final exec
      outr = 1'b1;
      start_seq(11);
      wait_exec(16);
      repeat (10) @(posedge clk);
      #1;
      outr = 1'b0;
      wait_sfin();
      chk("t5_sfin_once", sfin_cnt, 5);

      // Abort mid-sequence, with an ignored s_init during exec
      start_seq(4);
      wait_exec(5);
      s_init = 1'b1;
      @(posedge clk); #1;
      s_init = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ia.delete(); exp_wa.delete();
      pend = 0; prev_exec = 0; prev_kinit = 0; prev_sfin = 0; sfin_exp = 0;
      sfin_before = sfin_cnt;
      chk("abort_busy", busy, 0);
      chk("abort_kinit", k_init, 0);
      chk("abort_kfin", k_fin, 0);
      chk("abort_exec", exec, 0);
      chk("abort_ia", ia, 0);
      chk("abort_wa", wa, 0);
      chk("abort_sfin", s_fin, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_idle_busy", busy, 0);
      chk("abort_no_sfin", sfin_cnt, sfin_before);
      start_seq(4);
      wait_sfin();
      check_t1_log();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
